// File: rtl/mmio_responder.sv
// mmio_responder
// Memory-mapped I/O responder on the CPU data-memory port. It decodes a
// 256-byte window at BASE and answers loads and stores there in place of
// the data RAM. It holds the board LED register, the seven-segment display
// register and a prescaled 32-bit timer with compare match and interrupt.
//
// Ports:
//   clk     system clock, all state changes on the rising edge
//   rst     synchronous, active-low reset
//   addr    byte address of the access (addr[1:0] ignored)
//   wdata   store data
//   wren    store strobe, one cycle per store
//   rden    load strobe, one cycle per load
//   hit     combinational window decode (addr[31:8] == BASE[31:8])
//   rdata   registered load data, held until the next accepted read
//   rvalid  one-cycle pulse marking fresh rdata
//   LEDR    LED register
//   PCSEG   seven-segment register
//   irq     registered timer interrupt (match flag AND irq_en)
//
// Register map (word offset within the window):
//   0x00 LED [9:0]   0x04 SEG [23:0]   0x08 COUNT   0x0C COMPARE
//   0x10 CTRL {irq_en, auto_reload, enable}   0x14 STATUS {match}, W1C
module mmio_responder #(
  parameter logic [31:0] BASE     = 32'hFFFF0000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wren,
  input  logic        rden,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic [9:0]  LEDR,
  output logic [23:0] PCSEG,
  output logic        irq
);

  localparam int unsigned    PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [5:0] {
    REG_LED     = 6'h00,
    REG_SEG     = 6'h01,
    REG_COUNT   = 6'h02,
    REG_COMPARE = 6'h03,
    REG_CTRL    = 6'h04,
    REG_STATUS  = 6'h05
  } reg_idx_e;

  logic [31:0]   count_q;
  logic [31:0]   compare_q;
  logic [2:0]    ctrl_q;
  logic          match_q;
  logic [PW-1:0] psc_q;

  logic [5:0]    word;
  logic          wr_acc;
  logic          rd_acc;
  logic          tick;
  logic          match_set;
  logic          status_clr;
  logic          match_d;
  logic [31:0]   count_d;
  logic [PW-1:0] psc_d;
  logic [31:0]   rd_mux;
  logic          unused_addr_bits;

  assign hit              = (addr[31:8] == BASE[31:8]);
  assign word             = addr[7:2];
  assign unused_addr_bits = ^addr[1:0];

  // A store and a load in the same cycle: the store wins, the load is dropped.
  assign wr_acc = hit && wren;
  assign rd_acc = hit && rden && !wren;

  assign tick = ctrl_q[0] && (psc_q == PS_LAST);

  // Prescaler is held at zero while disabled so a re-enable always starts a
  // full period.
  always_comb begin
    psc_d = psc_q + PW'(1);
    if (!ctrl_q[0] || tick) begin
      psc_d = '0;
    end
  end

  // A software COUNT write takes priority over the tick, and suppresses the
  // compare evaluation for that cycle.
  always_comb begin
    count_d   = count_q;
    match_set = 1'b0;
    if (wr_acc && (word == REG_COUNT)) begin
      count_d = wdata;
    end else if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        count_d   = ctrl_q[1] ? '0 : count_q + 32'd1;
      end else begin
        count_d = count_q + 32'd1;
      end
    end
  end

  // Setting beats clearing when a match and a W1C land together.
  assign status_clr = wr_acc && (word == REG_STATUS) && wdata[0];
  assign match_d    = match_set || (match_q && !status_clr);

  always_comb begin
    rd_mux = '0;
    case (word)
      REG_LED:     rd_mux = {22'd0, LEDR};
      REG_SEG:     rd_mux = {8'd0, PCSEG};
      REG_COUNT:   rd_mux = count_q;
      REG_COMPARE: rd_mux = compare_q;
      REG_CTRL:    rd_mux = {29'd0, ctrl_q};
      REG_STATUS:  rd_mux = {31'd0, match_q};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      LEDR      <= '0;
      PCSEG     <= '0;
      count_q   <= '0;
      compare_q <= '1;
      ctrl_q    <= '0;
      match_q   <= 1'b0;
      psc_q     <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      count_q <= count_d;
      match_q <= match_d;
      psc_q   <= psc_d;
      irq     <= match_q && ctrl_q[2];
      rvalid  <= rd_acc;
      if (rd_acc) begin
        rdata <= rd_mux;
      end
      if (wr_acc) begin
        case (word)
          REG_LED:     LEDR      <= wdata[9:0];
          REG_SEG:     PCSEG     <= wdata[23:0];
          REG_COMPARE: compare_q <= wdata;
          REG_CTRL:    ctrl_q    <= wdata[2:0];
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;

  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic        a_wren = 1'b0, a_rden = 1'b0, b_wren = 1'b0, b_rden = 1'b0;
  logic        a_hit, a_rvalid, a_irq, b_hit, b_rvalid, b_irq;
  logic [31:0] a_rdata, b_rdata;
  logic [9:0]  a_ledr, b_ledr;
  logic [23:0] a_pcseg, b_pcseg;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  mmio_responder #(.BASE(BASE), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .addr(a_addr), .wdata(a_wdata), .wren(a_wren),
    .rden(a_rden), .hit(a_hit), .rdata(a_rdata), .rvalid(a_rvalid),
    .LEDR(a_ledr), .PCSEG(a_pcseg), .irq(a_irq)
  );

  mmio_responder #(.BASE(BASE), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .addr(b_addr), .wdata(b_wdata), .wren(b_wren),
    .rden(b_rden), .hit(b_hit), .rdata(b_rdata), .rvalid(b_rvalid),
    .LEDR(b_ledr), .PCSEG(b_pcseg), .irq(b_irq)
  );

  // Reference model: register file plus a count of consecutive enabled
  // cycles; a tick is every PRESCALE-th enabled cycle.
  typedef struct packed {
    logic [9:0]  led;
    logic [23:0] seg;
    logic [31:0] count;
    logic [31:0] cmp;
    logic [2:0]  ctrl;
    logic        match;
    logic        irq;
    logic        rvalid;
    logic [31:0] rdata;
    int unsigned en_run;
  } mstate_t;

  mstate_t ms [2];

  function automatic logic [31:0] mread(input mstate_t s, input logic [7:0] o);
    case (o)
      8'h00:   return {22'd0, s.led};
      8'h04:   return {8'd0, s.seg};
      8'h08:   return s.count;
      8'h0C:   return s.cmp;
      8'h10:   return {29'd0, s.ctrl};
      8'h14:   return {31'd0, s.match};
      default: return 32'd0;
    endcase
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int unsigned p,
                                    input logic r, input logic [31:0] ad,
                                    input logic [31:0] wd, input logic we,
                                    input logic re);
    mstate_t    n;
    logic       in_win, wr, rd, tick, set;
    logic [7:0] o;
    n = s;
    if (!r) begin
      n.led = 0; n.seg = 0; n.count = 0; n.cmp = 32'hFFFFFFFF; n.ctrl = 0;
      n.match = 0; n.irq = 0; n.rvalid = 0; n.rdata = 0; n.en_run = 0;
      return n;
    end
    in_win = (ad >= BASE) && ((ad - BASE) < 32'd256);
    o      = ad[7:0] & 8'hFC;
    wr     = in_win && we;
    rd     = in_win && re && !we;
    tick   = s.ctrl[0] && ((s.en_run % p) == (p - 1));
    n.en_run = s.ctrl[0] ? s.en_run + 1 : 0;
    set = 1'b0;
    if (wr && o == 8'h08) n.count = wd;
    else if (tick) begin
      if (s.count == s.cmp) begin
        set = 1'b1;
        n.count = s.ctrl[1] ? 32'd0 : s.count + 32'd1;
      end else n.count = s.count + 32'd1;
    end
    if (wr) begin
      if (o == 8'h00) n.led  = wd[9:0];
      if (o == 8'h04) n.seg  = wd[23:0];
      if (o == 8'h0C) n.cmp  = wd;
      if (o == 8'h10) n.ctrl = wd[2:0];
    end
    n.match  = set || (s.match && !(wr && o == 8'h14 && wd[0]));
    n.irq    = s.match && s.ctrl[2];
    n.rvalid = rd;
    if (rd) n.rdata = mread(s, o);
    return n;
  endfunction

  always @(posedge clk) begin
    ms[0] <= mstep(ms[0], 1, rst, a_addr, a_wdata, a_wren, a_rden);
    ms[1] <= mstep(ms[1], 4, rst, b_addr, b_wdata, b_wren, b_rden);
  end

  function automatic logic [67:0] obs(input int unsigned i);
    if (i == 0) return {a_ledr, a_pcseg, a_irq, a_rvalid, a_rdata};
    return {b_ledr, b_pcseg, b_irq, b_rvalid, b_rdata};
  endfunction

  function automatic logic [67:0] expv(input int unsigned i);
    return {ms[i].led, ms[i].seg, ms[i].irq, ms[i].rvalid, ms[i].rdata};
  endfunction

  // One bus cycle on instance i; returns at the following falling edge.
  task automatic bus(input int unsigned i, input logic w, input logic r,
                     input logic [31:0] ad, input logic [31:0] wd);
    if (i == 0) begin a_addr = ad; a_wdata = wd; a_wren = w; a_rden = r; end
    else        begin b_addr = ad; b_wdata = wd; b_wren = w; b_rden = r; end
    @(negedge clk);
    a_wren = 1'b0; a_rden = 1'b0; b_wren = 1'b0; b_rden = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    vectors++;
    if ({a_ledr, a_pcseg, a_irq, a_rvalid, a_rdata} !== 68'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", obs(0));
    end
    bus(0, 1'b0, 1'b1, BASE + 32'h0C, 32'd0);
    vectors++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL reset_compare_read: rvalid=%b rdata=%h expected 1 ffffffff", a_rvalid, a_rdata);
    end
    @(negedge clk);
    vectors++;
    if (a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rvalid_pulse: rvalid=%b expected 0", a_rvalid);
    end
  endtask

  task automatic test_led_seg();
    bus(0, 1'b1, 1'b0, BASE, 32'h3FF);
    bus(0, 1'b1, 1'b0, BASE + 32'h04, 32'h00ABCDEF);
    vectors++;
    if (a_ledr !== 10'h3FF || a_pcseg !== 24'hABCDEF) begin
      errors++;
      $display("FAIL led_seg_write: LEDR=%h PCSEG=%h expected 3ff abcdef", a_ledr, a_pcseg);
    end
    bus(0, 1'b1, 1'b0, BASE - 32'd4, 32'h0);
    bus(0, 1'b1, 1'b0, BASE + 32'h100, 32'h0);
    vectors++;
    if (a_ledr !== 10'h3FF || a_pcseg !== 24'hABCDEF) begin
      errors++;
      $display("FAIL led_seg_miss: LEDR=%h PCSEG=%h expected 3ff abcdef", a_ledr, a_pcseg);
    end
    bus(0, 1'b0, 1'b1, BASE + 32'h04, 32'h0);
    vectors++;
    if (obs(0) !== expv(0)) begin
      errors++;
      $display("FAIL led_seg_readback: got %h expected %h", obs(0), expv(0));
    end
  endtask

  task automatic test_timer_reload();
    int unsigned irq_at;
    irq_at = 0;
    bus(0, 1'b1, 1'b0, BASE + 32'h0C, 32'd5);
    bus(0, 1'b1, 1'b0, BASE + 32'h08, 32'd0);
    bus(0, 1'b1, 1'b0, BASE + 32'h10, 32'h7);
    for (int unsigned k = 1; k <= 9; k++) begin
      bus(0, 1'b0, 1'b1, BASE + 32'h08, 32'd0);
      vectors++;
      if (obs(0) !== expv(0)) begin
        errors++;
        $display("FAIL timer_reload k=%0d: got %h expected %h", k, obs(0), expv(0));
      end
      if (a_irq === 1'b1 && irq_at == 0) irq_at = k;
    end
    vectors++;
    if (irq_at != 7) begin
      errors++;
      $display("FAIL timer_irq_timing: irq first at cycle %0d expected 7", irq_at);
    end
    bus(0, 1'b1, 1'b0, BASE + 32'h14, 32'd1);
    vectors++;
    if (a_irq !== 1'b1) begin
      errors++;
      $display("FAIL timer_w1c_same: irq=%b expected 1", a_irq);
    end
    @(negedge clk);
    vectors++;
    if (a_irq !== 1'b0) begin
      errors++;
      $display("FAIL timer_w1c_drop: irq=%b expected 0", a_irq);
    end
    bus(0, 1'b1, 1'b0, BASE + 32'h10, 32'h0);
  endtask

  task automatic test_no_reload();
    logic [31:0] want [4];
    want = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    bus(0, 1'b1, 1'b0, BASE + 32'h14, 32'd1);
    bus(0, 1'b1, 1'b0, BASE + 32'h08, 32'hFFFFFFFE);
    bus(0, 1'b1, 1'b0, BASE + 32'h0C, 32'd0);
    bus(0, 1'b1, 1'b0, BASE + 32'h10, 32'h1);
    for (int unsigned k = 0; k < 4; k++) begin
      bus(0, 1'b0, 1'b1, BASE + 32'h08, 32'd0);
      vectors++;
      if (a_rdata !== want[k] || obs(0) !== expv(0)) begin
        errors++;
        $display("FAIL no_reload_count k=%0d: rdata=%h expected %h (full %h vs %h)",
                 k, a_rdata, want[k], obs(0), expv(0));
      end
    end
    bus(0, 1'b0, 1'b1, BASE + 32'h14, 32'd0);
    vectors++;
    if (a_rdata !== 32'd1 || a_irq !== 1'b0) begin
      errors++;
      $display("FAIL no_reload_status: status=%h irq=%b expected 1 0", a_rdata, a_irq);
    end
    bus(0, 1'b1, 1'b0, BASE + 32'h10, 32'h0);
    bus(0, 1'b1, 1'b0, BASE + 32'h14, 32'd1);
  endtask

  task automatic test_collisions();
    bus(0, 1'b1, 1'b0, BASE + 32'h08, 32'd10);
    bus(0, 1'b1, 1'b0, BASE + 32'h0C, 32'd10);
    bus(0, 1'b1, 1'b0, BASE + 32'h10, 32'h1);
    bus(0, 1'b1, 1'b0, BASE + 32'h08, 32'd100);
    bus(0, 1'b0, 1'b1, BASE + 32'h08, 32'd0);
    vectors++;
    if (a_rdata !== 32'd100) begin
      errors++;
      $display("FAIL collide_count_write: COUNT=%0d expected 100", a_rdata);
    end
    bus(0, 1'b0, 1'b1, BASE + 32'h14, 32'd0);
    vectors++;
    if (a_rdata !== 32'd0) begin
      errors++;
      $display("FAIL collide_count_nomatch: STATUS=%h expected 0", a_rdata);
    end
    bus(0, 1'b1, 1'b0, BASE + 32'h10, 32'h0);
    bus(0, 1'b1, 1'b0, BASE + 32'h08, 32'd20);
    bus(0, 1'b1, 1'b0, BASE + 32'h0C, 32'd20);
    bus(0, 1'b1, 1'b0, BASE + 32'h10, 32'h1);
    bus(0, 1'b1, 1'b0, BASE + 32'h14, 32'd1);
    bus(0, 1'b0, 1'b1, BASE + 32'h14, 32'd0);
    vectors++;
    if (a_rdata !== 32'd1) begin
      errors++;
      $display("FAIL collide_w1c_match: STATUS=%h expected 1", a_rdata);
    end
    bus(0, 1'b1, 1'b0, BASE + 32'h10, 32'h0);
    bus(0, 1'b1, 1'b0, BASE + 32'h14, 32'd1);
    bus(0, 1'b1, 1'b1, BASE, 32'h155);
    vectors++;
    if (a_rvalid !== 1'b0 || a_ledr !== 10'h155) begin
      errors++;
      $display("FAIL collide_wr_rd: rvalid=%b LEDR=%h expected 0 155", a_rvalid, a_ledr);
    end
  endtask

  task automatic test_prescale();
    int unsigned first;
    logic [31:0] base_cnt;
    first = 0;
    bus(1, 1'b1, 1'b0, BASE + 32'h10, 32'h1);
    for (int unsigned k = 1; k <= 12; k++) begin
      bus(1, 1'b0, 1'b1, BASE + 32'h08, 32'd0);
      vectors++;
      if (obs(1) !== expv(1)) begin
        errors++;
        $display("FAIL prescale_run k=%0d: got %h expected %h", k, obs(1), expv(1));
      end
      if (first == 0 && b_rdata !== 32'd0) first = k;
    end
    vectors++;
    if (first != 5) begin
      errors++;
      $display("FAIL prescale_first_tick: first change at read %0d expected 5", first);
    end
    repeat (2) @(negedge clk);
    bus(1, 1'b1, 1'b0, BASE + 32'h10, 32'h0);
    bus(1, 1'b0, 1'b1, BASE + 32'h08, 32'd0);
    base_cnt = b_rdata;
    bus(1, 1'b1, 1'b0, BASE + 32'h10, 32'h1);
    first = 0;
    for (int unsigned k = 1; k <= 6; k++) begin
      bus(1, 1'b0, 1'b1, BASE + 32'h08, 32'd0);
      if (first == 0 && b_rdata !== base_cnt) first = k;
    end
    vectors++;
    if (first != 5) begin
      errors++;
      $display("FAIL prescale_reenable: first change at read %0d expected 5", first);
    end
    bus(1, 1'b1, 1'b0, BASE + 32'h10, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] ad, wd;
    logic        w, r, exp_hit;
    for (int unsigned c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      for (int unsigned i = 0; i < 2; i++) begin
        case ($urandom_range(0, 9))
          0:       ad = $urandom;
          1:       ad = BASE - 32'd4;
          2:       ad = BASE + 32'h100;
          default: ad = BASE + 32'($urandom_range(0, 8)) * 32'd4 + 32'($urandom_range(0, 3));
        endcase
        wd = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
        w  = ($urandom_range(0, 3) == 0);
        r  = ($urandom_range(0, 2) == 0);
        if (i == 0) begin a_addr = ad; a_wdata = wd; a_wren = w; a_rden = r; end
        else        begin b_addr = ad; b_wdata = wd; b_wren = w; b_rden = r; end
      end
      #1;
      exp_hit = (a_addr >= BASE) && ((a_addr - BASE) < 32'd256);
      vectors++;
      if (a_hit !== exp_hit) begin
        errors++;
        $display("FAIL random_hit c=%0d addr=%h: hit=%b expected %b", c, a_addr, a_hit, exp_hit);
      end
      @(negedge clk);
      for (int unsigned i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== expv(i)) begin
          errors++;
          $display("FAIL random_state c=%0d dut=%0d: got %h expected %h", c, i, obs(i), expv(i));
        end
      end
    end
    rst = 1'b1;
    a_wren = 1'b0; a_rden = 1'b0; b_wren = 1'b0; b_rden = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_led_seg();
    test_timer_reload();
    test_no_reload();
    test_collisions();
    test_prescale();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the CPU data-memory port: it answers loads and stores whose address falls in the MMIO window instead of the data RAM. It holds the board LED register, the seven-segment display register and a programmable timer with compare match and interrupt. The CPU is the initiator. This block is the responder end of the same address/wdata/wren access.

## Interface
Parameters:
- BASE, 32'hFFFF0000, MMIO window base (MARS MMIO region); window is BASE..BASE+0xFF.
- PRESCALE, 1, timer tick period in clk cycles (≥1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-low.
- addr  in  32  byte address of the access (Rs + offset from ALU).
- wdata  in  32  store data (Rt).
- wren  in  1  store strobe, one cycle per store.
- rden  in  1  load strobe, one cycle per load.
- hit  out  1  combinational; 1 when addr[31:8] == BASE[31:8].
- rdata  out  32  registered load data.
- rvalid  out  1  registered; 1 for exactly one cycle when rdata is fresh.
- LEDR  out  10  LED register.
- PCSEG  out  24  seven-segment register.
- irq  out  1  registered timer interrupt.

## Operation
- Register map (offset = addr[7:0]; addr[1:0] ignored):
  - 0x00 LED (RW, bits [9:0]).
  - 0x04 SEG (RW, bits [23:0]).
  - 0x08 COUNT (RW, 32 bits).
  - 0x0C COMPARE (RW, 32 bits).
  - 0x10 CTRL (RW): bit0 enable, bit1 auto-reload, bit2 irq_en.
  - 0x14 STATUS: bit0 match flag. Reads return it. Writing 1 clears it and writing 0 has no effect.
- Unused register bits read 0. Unmapped offsets read 0, and writes to them are ignored.
- An access is taken only when hit=1. When hit=0, the block ignores wren and rden completely.
- If wren and rden are both 1 with hit, the write is performed and the read is dropped; rvalid stays 0.
- Prescaler:
  - The prescaler counter counts 0..PRESCALE-1 while enable=1.
  - A tick occurs on the cycle it equals PRESCALE-1; the counter then returns to 0.
  - The prescaler clears when enable=0.
- Timer on a tick, with no software write to COUNT that cycle:
  - If COUNT == COMPARE, the match flag sets. COUNT then becomes 0 if auto-reload=1, else COUNT+1.
  - Otherwise COUNT becomes COUNT+1, wrapping modulo 2^32.
- Simultaneous events:
  - A software write to COUNT in the same cycle as a tick wins; no match is evaluated that cycle.
  - A match-set and a STATUS W1C in the same cycle leave the flag set.
- irq is registered as (match flag AND irq_en).

## Timing
- Reset (rst=0 at a clock edge) sets the following values:
  - LED=0, SEG=0, COUNT=0, COMPARE=32'hFFFFFFFF, CTRL=0, match flag=0, prescaler=0.
  - Outputs rdata=0, rvalid=0, irq=0.
- Reset asserted mid-operation aborts any pending read: rvalid is 0 on the next cycle.
- Writes take effect at the edge where wren=1, hit=1 and rst=1. LEDR and PCSEG show the new value right after that edge.
- Read latency is one cycle:
  - A read with rden=1 and hit=1 at edge N samples the register contents present before edge N.
  - rdata holds that value from edge N; rvalid=1 from edge N until edge N+1.
- rdata holds its last value until the next accepted read. Back-to-back reads on consecutive cycles are supported.
- For PRESCALE=1, a tick occurs every enabled cycle.
- Match timing: the match flag is 1 the edge after the tick on which COUNT==COMPARE. irq follows one edge later.

## Test plan
- Reset: hold rst=0 for 2 cycles, then read 0x0C -> rdata=32'hFFFFFFFF and rvalid pulses 1 cycle. LEDR=0, PCSEG=0, irq=0.
- LED/SEG: store 32'h3FF to BASE+0x00 and 32'h00ABCDEF to BASE+0x04 -> LEDR=10'h3FF, PCSEG=24'hABCDEF. Store to BASE-4 (hit=0) -> no change.
- Timer with PRESCALE=1:
  - Setup: COMPARE=5, CTRL=3'b111.
  - Required: COUNT runs 0..5; match flag sets; COUNT reloads to 0; irq=1 two edges after the COUNT=5 cycle.
  - Then W1C STATUS=1 -> irq drops the next cycle.
- No auto-reload: COUNT=32'hFFFFFFFE, COMPARE=0, CTRL=1 -> COUNT wraps FFFFFFFF -> 0 -> 1. The match flag sets after the 0 tick and irq stays 0.
- Collisions:
  - Software write COUNT=100 on a match tick -> COUNT=100 and the flag is not set.
  - W1C STATUS on the same cycle as a match -> flag remains 1.
  - wren and rden together -> rvalid=0.
- Prescaler, PRESCALE=4: enable timer -> COUNT increments every 4th cycle. Clear enable mid-period and re-enable -> first increment comes 4 cycles later.
